riscv_if: RTL and testbench
===========================

Name: riscv_if

Overview:
- Instruction fetch stage of the riscv pipeline; produces the `instruction`/`pc` pair consumed by the decode stage.
- Generates sequential fetch addresses and issues requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents them downstream with valid/ready.
- Handles control-flow redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- XLEN, 32: data/address width.
- RESET_PC, 0: first fetch address after reset.
- DEPTH, 2: fetch buffer depth and maximum in-flight requests; power of two, ≥2.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  XLEN  fetch address.
- mem_resp_valid  input  1  response valid, in order, one per accepted request, earliest the cycle after acceptance.
- mem_resp_data  input  XLEN  fetched instruction word.
- redirect  input  1  control-flow change (branch/jump/trap), single-cycle pulse.
- redirect_pc  input  XLEN  new fetch target.
- instruction  output  XLEN  head instruction to decode.
- pc  output  XLEN  address of the head instruction.
- valid  output  1  instruction/pc valid.
- ready  input  1  decode accepts head.
- exception  output  1  sticky instruction-address-misaligned flag.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; buffer empty; outstanding=0; discard=0; exception=0; mem_req_valid=0; valid=0; instruction=0; pc=0.
- Request issue:
  - mem_req_valid=1 when outstanding + buffer count < DEPTH, redirect=0, and exception=0.
  - mem_req_addr = fetch_pc.
  - Accept is mem_req_valid & mem_req_ready. On accept: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1; the request address is pushed into an address-tag FIFO of depth DEPTH.
- Response:
  - On mem_resp_valid: pop the address tag; outstanding -= 1.
  - If discard>0: drop the response; discard -= 1.
  - Otherwise push {tag address, mem_resp_data} into the buffer.
  - mem_resp_valid with outstanding=0 is a protocol violation; the bench must flag it.
- Simultaneous accept and response in one cycle: outstanding is unchanged.
- Output:
  - valid = buffer non-empty; instruction/pc = buffer head, driven from registers.
  - Pop on valid & ready.
  - Latency: response cycle N gives valid=1 at cycle N+1. Minimum fetch latency is request accept N → valid N+2 with a 1-cycle memory.
- Full buffer: the credit rule guarantees a response is never dropped for lack of space; push and pop in the same cycle are legal.
- Redirect (takes priority over every other event that cycle):
  - Flush the buffer; valid=0 the next cycle.
  - fetch_pc = redirect_pc.
  - discard = outstanding, minus 1 if a response arrives that cycle; that response is dropped.
  - A pop in the redirect cycle is ignored (the flush wins).
  - No request is issued in the redirect cycle; the first request to redirect_pc is presented the next cycle.
  - Back-to-back redirects: each reloads fetch_pc and recomputes discard from the current outstanding count.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - exception=1 next cycle, sticky until reset.
  - Buffer flushed, no further requests.
  - In-flight responses are still drained and dropped.
- Reset mid-operation: all state is cleared immediately. Memory must also be reset, so no stale responses arrive afterwards.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory returning addr+0x100, ready=1 → requests 0x0, 0x4, 0x8…; valid first at the 3rd clock with pc=0, instruction=0x100; thereafter one instruction per cycle.
- ready=0 held → at most DEPTH=2 requests accepted, then mem_req_valid=0. After ready=1, pcs 0x0, 0x4 are delivered in order with no loss.
- mem_req_ready toggling 1010…, responses delayed 3 cycles → output pc sequence strictly +4, no gaps or duplicates.
- Redirect to 0x200 with 2 requests outstanding → both responses dropped; next valid has pc=0x200; mem_req_addr sequence continues 0x204.
- Redirect to 0x300 in the same cycle as a response and a pop → response dropped; head not consumed but flushed; first output pc=0x300.
- Redirect to 0x202 → exception=1 next cycle, mem_req_valid stays 0, valid stays 0; reset clears exception.

Source files
------------

// File: rtl/riscv_if.sv
// Instruction fetch stage: issues sequential fetches, buffers responses, presents instruction/pc to decode.
// Latency: request accepted in cycle N -> response N+1 (fastest memory) -> valid in cycle N+2.
// Backpressure: a request is issued only while outstanding + buffered < DEPTH, so a response always has a slot.

// Small circular buffer with a synchronous flush; head is read straight from the storage registers.
module riscv_if_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage and pointers; flush discards everything and takes priority over push/pop.
    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

module riscv_if #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            valid,
    input  logic            ready,
    output logic            exception
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   fetch_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     discard;
    logic [CW:0]       credit_used;
    logic [XLEN-1:0]   tag_head;
    logic [2*XLEN-1:0] buf_head;
    logic              accept;
    logic              resp_pop;
    logic              resp_keep;
    logic              out_pop;

    // Every slot is either in flight or sitting in the buffer; pops are not credited
    // in the same cycle, which keeps the issue decision off the decode ready path.
    assign credit_used   = {1'b0, outstanding} + {1'b0, buf_count};
    assign mem_req_valid = rst && !redirect && !exception && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol error; it is ignored rather
    // than allowed to underflow the tag queue.
    assign resp_pop  = mem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_pop && !redirect && (discard == '0);

    assign valid                = (buf_count != '0);
    assign out_pop              = valid && ready;
    assign {pc, instruction}    = buf_head;

    // Address tags of in-flight requests; its occupancy is the outstanding count.
    // Tags are never flushed, since discarded responses still pop their tag.
    riscv_if_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp_pop),
        .head      (tag_head),
        .count     (outstanding)
    );

    // Fetch buffer of {pc, instruction}; a redirect flushes it and overrides any pop.
    riscv_if_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_buf_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (resp_keep),
        .push_data ({tag_head, mem_resp_data}),
        .pop       (out_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Fetch address: reload on redirect, otherwise advance by one word per accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (accept) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Responses still owed to the stale path; a response arriving with the redirect is already dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard <= '0;
        end else if (redirect) begin
            discard <= outstanding - CW'(resp_pop);
        end else if (resp_pop && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

    // Sticky misaligned-target flag; it halts further fetching until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exception <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            exception <= 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_if.sv
// Bench for riscv_if: in-order memory model returning addr+0x100, scoreboard of expected pcs.
// Timing: inputs change on negedge, all sampling at negedge+4 (1 time unit before posedge).
// Expected output pcs are queued by the directed tests and checked by an independent monitor.
module tb_riscv_if;
    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic        exception;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] exp_q[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          tb_out = 0;
    logic        toggle = 1'b0;
    logic [31:0] exp_pc;
    req_t        new_req;

    riscv_if #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .pc             (pc),
        .valid          (valid),
        .ready          (ready),
        .exception      (exception)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory: answers in order, one response per cycle, no earlier than lat cycles after acceptance.
    always begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
            pend_q.delete();
            mem_resp_valid = 1'b0;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend_q[0].addr + 32'h100;
            void'(pend_q.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
        end
    end

    // Request capture and response protocol tracking.
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            tb_out = 0;
        end else begin
            if (mem_resp_valid) begin
                if (tb_out == 0) begin
                    errors++;
                    $display("FAIL resp_protocol: response with outstanding=%0d required >0", tb_out);
                end else begin
                    tb_out--;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                new_req.addr = mem_req_addr;
                new_req.due  = cyc + lat;
                pend_q.push_back(new_req);
                acc_q.push_back(mem_req_addr);
                tb_out++;
            end
        end
    end

    // Monitor: every consumed instruction must match the next expected pc; a redirect-cycle pop is void.
    always begin
        @(negedge clk);
        #4;
        if (rst && valid && ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h, expected no output", pc);
            end else begin
                exp_pc = exp_q.pop_front();
                check("out_pc", pc, exp_pc);
                check("out_instr", instruction, exp_pc + 32'h100);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        ready         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        toggle        = 1'b0;
        mem_req_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_valid", valid, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instruction, 0);
        check("rst_exception", exception, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            if (toggle) mem_req_ready = ~mem_req_ready;
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic bad_req;
        logic bad_valid;
        rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_req_ready = 1'b1;

        // 1: streaming from reset, 1-cycle memory
        lat = 1;
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        @(negedge clk);
        check("t1_valid_cycle2", valid, 0);
        @(negedge clk);
        check("t1_valid_cycle3", valid, 1);
        check("t1_pc_cycle3", pc, 32'h0);
        check("t1_instr_cycle3", instruction, 32'h100);
        wait_empty("t1", 60);
        ready = 1'b0;
        check("t1_addr0", acc_at(0), 32'h0);
        check("t1_addr1", acc_at(1), 32'h4);
        check("t1_addr2", acc_at(2), 32'h8);

        // 2: decode stalled, credit limit, then in-order delivery
        lat = 1;
        do_reset();
        repeat (8) @(negedge clk);
        check("t2_accepts", 32'(acc_q.size()), 2);
        #1 check("t2_req_valid_held", mem_req_valid, 0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        ready = 1'b1;
        wait_empty("t2", 30);
        ready = 1'b0;

        // 3: toggling request ready, 3-cycle memory
        lat = 3;
        do_reset();
        toggle = 1'b1;
        ready  = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        wait_empty("t3", 150);
        toggle = 1'b0;
        ready  = 1'b0;
        mem_req_ready = 1'b1;

        // 4: redirect with two requests in flight
        lat = 3;
        do_reset();
        n = 0;
        while (acc_q.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_two_outstanding", 32'(acc_q.size()), 2);
        redirect = 1'b1; redirect_pc = 32'h200; ready = 1'b1;
        #1;
        check("t4_no_resp_at_redirect", mem_resp_valid, 0);
        check("t4_no_req_at_redirect", mem_req_valid, 0);
        @(negedge clk);
        redirect = 1'b0;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        wait_empty("t4", 60);
        ready = 1'b0;
        check("t4_addr_after_redirect", acc_at(2), 32'h200);
        check("t4_addr_next", acc_at(3), 32'h204);

        // 5: redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        n = 0;
        while (!valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_head_pc", pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h300; ready = 1'b1;
        #1 check("t5_resp_at_redirect", mem_resp_valid, 1);
        @(negedge clk);
        redirect = 1'b0;
        check("t5_flushed", valid, 0);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        wait_empty("t5", 40);
        ready = 1'b0;

        // 6: misaligned redirect, sticky exception, cleared by reset
        lat = 2;
        do_reset();
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h202; ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        check("t6_exception_set", exception, 1);
        bad_req = 1'b0;
        bad_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (mem_req_valid) bad_req = 1'b1;
            if (valid) bad_valid = 1'b1;
        end
        check("t6_no_requests", bad_req, 0);
        check("t6_no_output", bad_valid, 0);
        check("t6_exception_sticky", exception, 1);
        ready = 1'b0;
        do_reset();
        #1;
        check("t6_exception_cleared", exception, 0);
        check("t6_fetch_resumes", mem_req_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
